// File: rtl/stage_sequencer_pkg.sv
// ============================================================================
// Module      : stage_sequencer_pkg
// Description : Shared stage codes and state encodings for the core sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_sequencer_pkg;

   typedef logic [1:0] stage_t;

   // Stage codes must match the control unit decode.
   localparam stage_t STAGE_LOAD    = 2'b00;
   localparam stage_t STAGE_FETCH   = 2'b01;
   localparam stage_t STAGE_DECODE  = 2'b10;
   localparam stage_t STAGE_EXECUTE = 2'b11;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_FETCH   = 3'd2;
   localparam logic [2:0] ST_DECODE  = 3'd3;
   localparam logic [2:0] ST_EXECUTE = 3'd4;
   localparam logic [2:0] ST_HALT    = 3'd5;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_INSTR_W = 12;
   localparam int DEF_CNT_W   = 16;

   function automatic stage_t stage_of(input logic [2:0] st);
      stage_t s;
      case (st)
         ST_FETCH:   s = STAGE_FETCH;
         ST_DECODE:  s = STAGE_DECODE;
         ST_EXECUTE: s = STAGE_EXECUTE;
         default:    s = STAGE_LOAD;
      endcase
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stage_sequencer_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stage_sequencer.sv
// ============================================================================
// Module      : stage_sequencer
// Description : Core state machine, program loader and retired-instruction
//               counter for the 12-bit RISC core. Optional macro
//               SINGLE_STEP_EN adds the step port for single-instruction runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic               run_start,
   input  logic               halt_req,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [INSTR_W-1:0] ld_data,
   input  logic               ld_last,
   output logic [1:0]         stage,
   output logic               core_en,
   output logic               pmem_we,
   output logic [ADDR_W-1:0]  pmem_addr,
   output logic [INSTR_W-1:0] pmem_wdata,
   output logic [ADDR_W:0]    prog_len,
   output logic [CNT_W-1:0]   instr_cnt,
   output logic               halted
`ifdef SINGLE_STEP_EN
   ,
   input  logic               step
`endif
);

   logic [2:0]        state;
   logic [ADDR_W-1:0] ld_cnt;
   logic              hs;
   logic              ld_end;
   logic              step_go;
   logic              step_mode;

   assign ld_ready   = (state == ST_LOAD);
   assign hs         = ld_valid & ld_ready;
   assign ld_end     = hs & (ld_last | (ld_cnt == {ADDR_W{1'b1}}));
   assign pmem_we    = hs;
   assign pmem_addr  = ld_cnt;
   assign pmem_wdata = ld_data;
   assign stage      = stage_of(state);
   assign core_en    = (state == ST_LOAD) | (state == ST_FETCH) |
                       (state == ST_DECODE) | (state == ST_EXECUTE);
   assign halted     = (state == ST_HALT);

`ifdef SINGLE_STEP_EN
   // run_start outranks step, even when run_start itself is blocked by halt_req.
   assign step_go = (state == ST_HALT) & ~load_start & ~run_start & step;

   always_ff @(posedge clk) begin
      if (rst) begin
         step_mode <= 1'b0;
      end else if (step_go) begin
         step_mode <= 1'b1;
      end else if (state == ST_EXECUTE) begin
         step_mode <= 1'b0;
      end
   end
`else
   assign step_go   = 1'b0;
   assign step_mode = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ld_cnt   <= '0;
         prog_len <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  state  <= ST_LOAD;
                  ld_cnt <= '0;
               end else if (run_start) begin
                  state <= ST_FETCH;
               end
            end
            ST_LOAD: begin
               if (ld_end) begin
                  prog_len <= {1'b0, ld_cnt} + 1'b1;
                  ld_cnt   <= '0;
                  state    <= ST_FETCH;
               end else if (hs) begin
                  ld_cnt <= ld_cnt + 1'b1;
               end
            end
            ST_FETCH:   state <= ST_DECODE;
            ST_DECODE:  state <= ST_EXECUTE;
            ST_EXECUTE: state <= (halt_req | step_mode) ? ST_HALT : ST_FETCH;
            ST_HALT: begin
               if (load_start) begin
                  state  <= ST_LOAD;
                  ld_cnt <= '0;
               end else if (run_start & ~halt_req) begin
                  state <= ST_FETCH;
               end else if (step_go) begin
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_instr_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (state == ST_EXECUTE),
      .count (instr_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// ============================================================================
// Module      : tb_stage_sequencer
// Description : Randomized scoreboard bench for stage_sequencer (small
//               address and counter widths so boundaries are reachable).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_sequencer;

   localparam int ADDR_W  = 3;
   localparam int INSTR_W = 12;
   localparam int CNT_W   = 4;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               load_start = 1'b0;
   logic               run_start = 1'b0;
   logic               halt_req = 1'b0;
   logic               ld_valid = 1'b0;
   logic               ld_last = 1'b0;
   logic [INSTR_W-1:0] ld_data = '0;
   logic               ld_ready;
   logic [1:0]         stage;
   logic               core_en;
   logic               pmem_we;
   logic [ADDR_W-1:0]  pmem_addr;
   logic [INSTR_W-1:0] pmem_wdata;
   logic [ADDR_W:0]    prog_len;
   logic [CNT_W-1:0]   instr_cnt;
   logic               halted;

   stage_sequencer #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .run_start  (run_start),
      .halt_req   (halt_req),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .stage      (stage),
      .core_en    (core_en),
      .pmem_we    (pmem_we),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .prog_len   (prog_len),
      .instr_cnt  (instr_cnt),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t wr_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  exp_cnt = 0;
   int  exp_len = 0;
   int  fix_words[3] = '{32'h8A1, 32'h305, 32'h100};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every write strobe must match the oldest outstanding expected word.
   always @(negedge clk) begin
      if (pmem_we !== 1'b0) begin
         if (wr_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     pmem_addr, pmem_wdata);
         end else begin
            wr_t e;
            e = wr_q.pop_front();
            chk("wr_addr", 32'(pmem_addr), 32'(e.addr));
            chk("wr_data", 32'(pmem_wdata), 32'(e.data));
         end
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_stage", 32'(stage), 32'd0);
      chk("rst_core_en", 32'(core_en), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_pmem_we", 32'(pmem_we), 32'd0);
      chk("rst_pmem_addr", 32'(pmem_addr), 32'd0);
      chk("rst_prog_len", 32'(prog_len), 32'd0);
      chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
   endtask

   // Load from IDLE/HALT; returns at posedge+1 with the core in DECODE.
   // vmode: 0 valid always, 1 alternating, 2 random.
   task automatic do_load(input int last_idx, input int vmode, input bit with_run, input bit fixed);
      int k;
      int guard;
      bit loading;
      bit v;
      load_start = 1'b1;
      run_start  = with_run;
      adv();
      load_start = 1'b0;
      run_start  = 1'b0;
      k = 0;
      guard = 0;
      loading = 1'b1;
      while (loading && guard < 100) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (guard % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         ld_valid  = v;
         ld_data   = (fixed && k < 3) ? INSTR_W'(fix_words[k]) : INSTR_W'($urandom);
         ld_last   = v ? (k == last_idx) : 1'($urandom_range(0, 1));
         halt_req  = 1'($urandom_range(0, 1));
         run_start = 1'($urandom_range(0, 1));
         if (v) begin
            wr_q.push_back('{addr: k, data: int'(ld_data)});
            if (k == last_idx || k == DEPTH - 1) begin
               loading = 1'b0;
               exp_len = k + 1;
            end
            k++;
         end
         @(negedge clk);
         chk("load_ld_ready", 32'(ld_ready), 32'd1);
         chk("load_core_en", 32'(core_en), 32'd1);
         chk("load_stage", 32'(stage), 32'd0);
         adv();
         guard++;
      end
      if (loading) begin
         n_tests++;
         n_fail++;
         $display("FAIL load_timeout: got %0d words accepted, expected load to finish", k);
      end
      // Auto-run cycle: an offered word must be refused.
      ld_valid  = 1'b1;
      ld_data   = INSTR_W'($urandom);
      ld_last   = 1'b0;
      run_start = 1'b0;
      halt_req  = 1'b0;
      @(negedge clk);
      chk("post_load_ready", 32'(ld_ready), 32'd0);
      chk("post_load_stage", 32'(stage), 32'd1);
      chk("prog_len", 32'(prog_len), 32'(exp_len));
      chk("post_load_addr", 32'(pmem_addr), 32'd0);
      chk("post_load_cnt", 32'(instr_cnt), 32'(exp_cnt));
      ld_valid = 1'b0;
      adv();
   endtask

   // Run n instructions and halt after the last; start=0 from FETCH, 1 from DECODE.
   task automatic run_n(input int n, input int start);
      for (int i = start; i < 3 * n; i++) begin
         if (i >= 3 * n - 2)  halt_req = 1'b1;
         else if (i % 3 == 2) halt_req = 1'b0;
         else                 halt_req = 1'($urandom_range(0, 1));
         run_start = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("run_stage", 32'(stage), 32'(i % 3 + 1));
         chk("run_core_en", 32'(core_en), 32'd1);
         chk("run_halted", 32'(halted), 32'd0);
         adv();
      end
      run_start = 1'b0;
      exp_cnt = (exp_cnt + n > CNT_MAX) ? CNT_MAX : exp_cnt + n;
      @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_stage", 32'(stage), 32'd0);
      chk("halt_core_en", 32'(core_en), 32'd0);
      chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
      adv();
   endtask

   // From HALT: run_start under halt_req is ignored, then a clean resume.
   task automatic resume();
      halt_req  = 1'b1;
      run_start = 1'b1;
      adv();
      @(negedge clk);
      chk("run_blocked", 32'(halted), 32'd1);
      halt_req = 1'b0;
      adv();
      run_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) adv();
      @(negedge clk);
      chk_reset();
      adv();
      rst = 1'b0;
      @(negedge clk);
      chk_reset();
      adv();

      // Fixed three-word program, load_start and run_start together.
      do_load(2, 0, 1'b1, 1'b1);
      run_n(4, 1);

      // Overflow without ld_last, alternating valid, from HALT.
      do_load(-1, 1, 1'b0, 1'b0);
      run_n(13, 1);
      resume();
      run_n(2, 0);

      repeat (4) begin
         do_load($urandom_range(0, DEPTH + 1), 2, 1'b0, 1'b0);
         run_n($urandom_range(1, 4), 1);
         resume();
         run_n($urandom_range(1, 3), 0);
      end

      // Reset during DECODE.
      resume();
      @(negedge clk);
      chk("pre_rst_fetch", 32'(stage), 32'd1);
      adv();
      @(negedge clk);
      chk("pre_rst_decode", 32'(stage), 32'd2);
      rst = 1'b1;
      adv();
      rst = 1'b0;
      exp_cnt = 0;
      exp_len = 0;
      @(negedge clk);
      chk_reset();
      adv();

      // run_start alone from IDLE.
      run_start = 1'b1;
      adv();
      run_start = 1'b0;
      run_n(2, 0);

      // Reset in the middle of a load.
      load_start = 1'b1;
      adv();
      load_start = 1'b0;
      for (int j = 0; j < 2; j++) begin
         ld_valid = 1'b1;
         ld_last  = 1'b0;
         ld_data  = INSTR_W'($urandom);
         wr_q.push_back('{addr: j, data: int'(ld_data)});
         @(negedge clk);
         adv();
      end
      ld_valid = 1'b0;
      rst = 1'b1;
      adv();
      rst = 1'b0;
      exp_cnt = 0;
      exp_len = 0;
      @(negedge clk);
      chk_reset();
      adv();

      do_load(1, 2, 1'b0, 1'b0);
      run_n(1, 1);

      chk("queue_empty", 32'(wr_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
